// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory sequencing arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int LAT_W = 3;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational picker: round-robin on ties unless fixed priority
// is selected, in which case port 0 always wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  input  logic       i_fixed_prio,
  output logic [1:0] o_gnt
);

  // One-hot grant; on a tie the port that did not win last time goes next.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11: begin
        if (i_fixed_prio || i_last_gnt) begin
          o_gnt = 2'b01;
        end else begin
          o_gnt = 2'b10;
        end
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: grants one of two requesters, holds the strobes for a
// fixed window, and acks with read data or an error for illegal addresses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall0_o,
  output logic        memread_o,
  output logic        memwrite_o,
  output logic [31:0] memaddr_o,
  output logic [31:0] writedata_o,
  input  logic [31:0] memdata_i
);

  localparam logic [31:0]      LP_MAX_ADDR = 32'(DEPTH - 4);
  localparam logic [LAT_W-1:0] LP_LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic             LP_FIXED    = (FIXED_PRIO != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_port;
  logic             r_err;
  logic [LAT_W-1:0] r_lat_cnt;
  logic             r_last_gnt;
  logic [31:0]      r_rdata;

  logic [1:0]  w_gnt;
  logic        w_grant;
  logic        w_sel_port;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_legal;
  logic        w_lat_done;
  logic        w_in_access;
  logic        w_in_resp;

  rr_arb2 u_arb (
    .i_req        ({req1_i, req0_i}),
    .i_last_gnt   (r_last_gnt),
    .i_fixed_prio (LP_FIXED),
    .o_gnt        (w_gnt)
  );

  assign w_grant     = (r_state == IDLE) && (w_gnt != 2'b00);
  assign w_sel_port  = w_gnt[1];
  assign w_lat_done  = (r_lat_cnt == {LAT_W{1'b0}});
  assign w_in_access = (r_state == ACCESS);
  assign w_in_resp   = (r_state == RESP);

  // Operand mux for the winning port plus the word-alignment/range check.
  always_comb begin
    if (w_sel_port == PORT_DBG) begin
      w_sel_we    = we1_i;
      w_sel_addr  = addr1_i;
      w_sel_wdata = wdata1_i;
    end else begin
      w_sel_we    = we0_i;
      w_sel_addr  = addr0_i;
      w_sel_wdata = wdata0_i;
    end
    w_sel_legal = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr <= LP_MAX_ADDR);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; rejected accesses skip the memory window entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          if (w_sel_legal) begin
            w_state_nxt = ACCESS;
          end else begin
            w_state_nxt = RESP;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (w_lat_done) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = ACCESS;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latches, latency counter, grant history and read-data holding.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we       <= 1'b0;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 32'h0000_0000;
      r_port     <= PORT_CPU;
      r_err      <= 1'b0;
      r_lat_cnt  <= {LAT_W{1'b0}};
      r_last_gnt <= PORT_DBG;
      r_rdata    <= 32'h0000_0000;
    end else if (w_grant) begin
      r_we       <= w_sel_we;
      r_addr     <= w_sel_addr;
      r_wdata    <= w_sel_wdata;
      r_port     <= w_sel_port;
      r_last_gnt <= w_sel_port;
      r_err      <= ~w_sel_legal;
      r_lat_cnt  <= LP_LAT_INIT;
      // Cleared here so the zero is already visible in the error ack cycle.
      if (!w_sel_legal) begin
        r_rdata <= 32'h0000_0000;
      end
    end else if (w_in_access) begin
      if (w_lat_done) begin
        if (!r_we) begin
          r_rdata <= memdata_i;
        end
      end else begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end
    end
  end

  assign memread_o   = w_in_access & ~r_we;
  assign memwrite_o  = w_in_access & r_we;
  assign memaddr_o   = w_in_access ? r_addr  : 32'h0000_0000;
  assign writedata_o = w_in_access ? r_wdata : 32'h0000_0000;
  assign ack0_o      = w_in_resp & (r_port == PORT_CPU);
  assign ack1_o      = w_in_resp & (r_port == PORT_DBG);
  assign err_o       = w_in_resp & r_err;
  assign rdata_o     = r_rdata;
  assign stall0_o    = req0_i & ~ack0_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded random/directed bench for dmem_arbiter with a word-level memory
// reference model; a second instance covers fixed priority.
module tb_dmem_arbiter;

  localparam int DEPTH = 32;
  localparam int LAT   = 3;
  localparam int WORDS = DEPTH / 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        ack0, ack1, err, stall0, memread, memwrite;
  logic [31:0] rdata, memaddr, writedata, memdata;
  logic [31:0] mem_arr [WORDS];
  logic [31:0] ref_mem [WORDS];

  logic        f_req0, f_req1, f_ack0, f_ack1, f_err, f_stall0, f_memread, f_memwrite;
  logic [31:0] f_rdata, f_memaddr, f_writedata;

  txn_t sb0 [$];
  txn_t sb1 [$];
  int   ack_order [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          strobe_cnt = 0;
  logic        win_we;
  logic [31:0] win_addr, win_wdata;
  logic [31:0] last_rdata = 32'h0;
  logic        rr_valid = 1'b0;
  int          rr_exp = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .MEM_LAT(LAT), .FIXED_PRIO(0)) u_dut (
    .clk_i(clk), .rst_i(rst_s),
    .req0_i(req_s[0]), .req1_i(req_s[1]), .we0_i(we_s[0]), .we1_i(we_s[1]),
    .addr0_i(addr_s[0]), .addr1_i(addr_s[1]), .wdata0_i(wdata_s[0]), .wdata1_i(wdata_s[1]),
    .ack0_o(ack0), .ack1_o(ack1), .rdata_o(rdata), .err_o(err), .stall0_o(stall0),
    .memread_o(memread), .memwrite_o(memwrite), .memaddr_o(memaddr),
    .writedata_o(writedata), .memdata_i(memdata)
  );

  dmem_arbiter #(.DEPTH(DEPTH), .MEM_LAT(1), .FIXED_PRIO(1)) u_fix (
    .clk_i(clk), .rst_i(rst_s),
    .req0_i(f_req0), .req1_i(f_req1), .we0_i(1'b0), .we1_i(1'b0),
    .addr0_i(32'h0), .addr1_i(32'h0), .wdata0_i(32'h0), .wdata1_i(32'h0),
    .ack0_o(f_ack0), .ack1_o(f_ack1), .rdata_o(f_rdata), .err_o(f_err), .stall0_o(f_stall0),
    .memread_o(f_memread), .memwrite_o(f_memwrite), .memaddr_o(f_memaddr),
    .writedata_o(f_writedata), .memdata_i(32'h5A5A_1234)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA000_0000 | 32'(i * 17);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural memory seen by the DUT.
  assign memdata = mem_arr[memaddr[4:2]];
  initial begin
    for (int i = 0; i < WORDS; i++) mem_arr[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (memwrite === 1'b1) mem_arr[memaddr[4:2]] = writedata;
    end
  end

  // Monitor: per-cycle protocol checks and scoreboard pop on every ack.
  initial begin
    txn_t t;
    int   p;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (rst_s !== 1'b1) begin
        sb0.delete(); sb1.delete();
        strobe_cnt = 0; last_rdata = 32'h0; rr_valid = 1'b0;
      end else begin
        chk("stall0", 32'(stall0), 32'(req_s[0] & ~ack0));
        chk("strobe_excl", 32'(memread & memwrite), 32'd0);
        if (memread | memwrite) begin
          if (strobe_cnt == 0) begin
            win_we = memwrite; win_addr = memaddr; win_wdata = writedata;
          end else begin
            chk("strobe_addr_stable", memaddr, win_addr);
            chk("strobe_kind_stable", 32'(memwrite), 32'(win_we));
          end
          strobe_cnt++;
        end else begin
          chk("idle_memaddr", memaddr, 32'h0);
          chk("idle_writedata", writedata, 32'h0);
        end
        if (ack0 & ack1) begin
          n_cmp++; n_bad++;
          $display("FAIL dual_ack: got ack0=1 ack1=1, required at most one");
        end else if (ack0 | ack1) begin
          p = ack1 ? 1 : 0;
          ack_order.push_back(p);
          if (rr_valid) chk("rr_order", 32'(p), 32'(rr_exp));
          rr_valid = req_s[1-p];
          rr_exp   = 1 - p;
          if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ack: got ack on port %0d, required no ack", p);
          end else begin
            if (p == 0) t = sb0.pop_front(); else t = sb1.pop_front();
            chk("err", 32'(err), 32'(t.err));
            if (t.err) begin
              chk("err_strobes", 32'(strobe_cnt), 32'd0);
              chk("err_rdata", rdata, 32'h0);
              last_rdata = 32'h0;
            end else begin
              chk("strobe_cycles", 32'(strobe_cnt), 32'(LAT));
              chk("mem_addr", win_addr, t.addr);
              chk("mem_kind", 32'(win_we), 32'(t.we));
              if (t.we) begin
                chk("mem_wdata", win_wdata, t.wdata);
                chk("wr_rdata_hold", rdata, last_rdata);
                ref_mem[t.addr[4:2]] = t.wdata;
              end else begin
                chk("rdata", rdata, ref_mem[t.addr[4:2]]);
                last_rdata = ref_mem[t.addr[4:2]];
              end
            end
          end
          strobe_cnt = 0;
        end else begin
          chk("err_no_ack", 32'(err), 32'd0);
          chk("rdata_hold", rdata, last_rdata);
        end
      end
    end
  end

  task automatic do_txn(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input int exp_lat);
    txn_t t;
    int   waited;
    logic got;
    we_s[p] = we; addr_s[p] = addr; wdata_s[p] = wd; req_s[p] = 1'b1;
    t.we = we; t.addr = addr; t.wdata = wd;
    t.err = !((addr % 32'd4 == 32'd0) && (addr <= 32'(DEPTH - 4)));
    if (p == 0) sb0.push_back(t); else sb1.push_back(t);
    got = 1'b0; waited = 0;
    while (!got && waited < 100) begin
      @(negedge clk);
      if ((p == 0 && ack0) || (p == 1 && ack1)) got = 1'b1; else waited++;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: port %0d addr 0x%0h got no ack, required ack within 100 cycles", p, addr);
    end else if (exp_lat >= 0) begin
      chk("latency", 32'(waited), 32'(exp_lat));
    end
    @(posedge clk); #1; req_s[p] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rand_port(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int          gap;
      int          sel;
      logic [31:0] a;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, WORDS - 1)) * 32'd4;
      else if (sel < 9) a = 32'($urandom_range(0, WORDS - 1)) * 32'd4 + 32'($urandom_range(1, 3));
      else              a = 32'(DEPTH) + 32'($urandom_range(0, 3)) * 32'd4;
      do_txn(p, 1'($urandom_range(0, 1)), a, $urandom, -1);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack0"}, 32'(ack0), 32'd0);
    chk({tag, "_ack1"}, 32'(ack1), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_memread"}, 32'(memread), 32'd0);
    chk({tag, "_memwrite"}, 32'(memwrite), 32'd0);
    chk({tag, "_memaddr"}, memaddr, 32'h0);
    chk({tag, "_writedata"}, writedata, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_stall0"}, 32'(stall0), 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_s = 1'b0; req_s[0] = 1'b0; req_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1; rst_s = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_s = 1'b0; f_req0 = 1'b0; f_req1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
    end
    apply_reset();

    // Latency window with MEM_LAT=3: strobes cycles 1..3, ack in 4.
    fork
      do_txn(0, 1'b0, 32'h10, 32'h0, LAT + 1);
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          chk("win_memread", 32'(memread), 32'(k >= 1 && k <= LAT));
          chk("win_ack0", 32'(ack0), 32'(k == LAT + 1));
          chk("win_stall0", 32'(stall0), 32'(k <= LAT));
        end
      end
    join

    do_txn(0, 1'b1, 32'h08, 32'hDEAD_BEEF, LAT + 1);
    do_txn(0, 1'b0, 32'h08, 32'h0, LAT + 1);
    chk("wr_then_rd", rdata, 32'hDEAD_BEEF);
    do_txn(1, 1'b0, 32'h05, 32'h0, 1);
    chk("misaligned_rdata", rdata, 32'h0);
    do_txn(0, 1'b1, 32'h1D, 32'h1234_5678, 1);
    do_txn(0, 1'b1, 32'h20, 32'h1234_5678, 1);
    do_txn(0, 1'b1, 32'h1C, 32'hCAFE_F00D, LAT + 1);
    do_txn(0, 1'b0, 32'h1C, 32'h0, LAT + 1);
    chk("top_word", rdata, 32'hCAFE_F00D);

    // Simultaneous reads of 0x00 straight out of reset alternate 0,1,0,1.
    apply_reset();
    ack_order.delete();
    fork
      begin do_txn(0, 1'b0, 32'h0, 32'h0, -1); do_txn(0, 1'b0, 32'h0, 32'h0, -1); end
      begin do_txn(1, 1'b0, 32'h0, 32'h0, -1); do_txn(1, 1'b0, 32'h0, 32'h0, -1); end
    join
    chk("alt_count", 32'(ack_order.size()), 32'd4);
    for (int i = 0; i < ack_order.size() && i < 4; i++) chk("alt_grant", 32'(ack_order[i]), 32'(i % 2));

    // Reset pulled in the second ACCESS cycle of a port-0 read.
    we_s[0] = 1'b0; addr_s[0] = 32'h0C; req_s[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_pre_memread", 32'(memread), 32'd1);
    rst_s = 1'b0; req_s[0] = 1'b0;
    #1;
    chk_quiet("abort");
    repeat (2) @(negedge clk);
    chk_quiet("abort_hold");
    @(posedge clk); #1; rst_s = 1'b1;
    @(posedge clk); #1;
    ack_order.delete();
    fork
      do_txn(0, 1'b0, 32'h04, 32'h0, -1);
      do_txn(1, 1'b0, 32'h04, 32'h0, -1);
    join
    chk("post_reset_count", 32'(ack_order.size()), 32'd2);
    if (ack_order.size() > 0) chk("post_reset_first", 32'(ack_order[0]), 32'd0);

    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join

    // Fixed priority, MEM_LAT=1: port 1 starves while req0 is held.
    f_req0 = 1'b1; f_req1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("fix_ack0", 32'(f_ack0), 32'(k % 3 == 2));
      chk("fix_ack1", 32'(f_ack1), 32'd0);
      chk("fix_memread", 32'(f_memread), 32'(k % 3 == 1));
      chk("fix_memwrite", 32'(f_memwrite), 32'd0);
      chk("fix_stall0", 32'(f_stall0), 32'(k % 3 != 2));
      chk("fix_err", 32'(f_err), 32'd0);
      chk("fix_memaddr", f_memaddr, 32'h0);
      chk("fix_writedata", f_writedata, 32'h0);
      if (k % 3 == 2) chk("fix_rdata", f_rdata, 32'h5A5A_1234);
    end
    @(posedge clk); #1; f_req0 = 1'b0; f_req1 = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencing controller and two-port arbiter in front of the byte-addressed data memory. Port 0 is the CPU MEM stage; port 1 is the debug/loader path. The block grants one requester at a time and holds the memory read/write strobes, address and write data stable for a fixed access window. It returns read data with a one-cycle acknowledge and rejects misaligned or out-of-range word accesses without touching memory.

## Interface
Parameters:
- `DEPTH`, 32: memory size in bytes; must be a multiple of 4.
- `MEM_LAT`, 1: cycles the strobes are held per access; legal range 1..7.
- `FIXED_PRIO`, 0: 0 selects round-robin arbitration; 1 means port 0 always wins.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `req0_i`, `req1_i`  in  1  access request, held until the matching ack.
- `we0_i`, `we1_i`  in  1  1 = word write, 0 = word read.
- `addr0_i`, `addr1_i`  in  32  byte address.
- `wdata0_i`, `wdata1_i`  in  32  write data.
- `ack0_o`, `ack1_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  read data; valid in the ack cycle and held until the next ack.
- `err_o`  out  1  qualifies the ack; high means the access was rejected.
- `stall0_o`  out  1  `req0_i & ~ack0_o`; drives the CPU pipeline stall.
- `memread_o`, `memwrite_o`  out  1  memory strobes.
- `memaddr_o`, `writedata_o`  out  32  memory address and write data.
- `memdata_i`  in  32  memory read data (combinational).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If any request is present, pick a winner and latch its we/addr/wdata and port id.
  - Legal address: `addr[1:0]==0` and `addr <= DEPTH-4`. A legal access goes to ACCESS and loads `lat_cnt = MEM_LAT-1`.
  - An illegal access goes straight to RESP with err set.
- **ACCESS:**
  - `memread_o = ~we`, `memwrite_o = we`; address and data come from the latched registers.
  - `lat_cnt` decrements each cycle. At `lat_cnt==0`, capture `memdata_i` into `rdata_o` for reads, then go to RESP.
- **RESP:**
  - Pulse `ack` for the latched port; `err_o = err`; then go to IDLE.
  - On error, `rdata_o` is set to 0.
  - On a write, `rdata_o` keeps its previous value.
- **Arbitration:**
  - A `last_gnt` register is updated at every grant; reset value is 1, so port 0 wins the first tie.
  - With both requests present, the port not equal to `last_gnt` wins.
  - With `FIXED_PRIO=1`, port 0 always wins.
- **Requester contract:**
  - Hold req and operands until ack; drop req the cycle after ack.
  - The arbiter does not sample requests in RESP, so a held req is never double-granted.
- **Strobes:**
  - `memread_o` and `memwrite_o` are never high together.
  - Both strobes are 0 in IDLE and RESP.
  - `memaddr_o` and `writedata_o` are 0 outside ACCESS.
- **Reset values:** state IDLE; all outputs 0; `last_gnt=1`; `rdata_o=0`.

## Timing
- Legal access, request sampled in cycle 0:
  - Strobes are high in cycles 1..MEM_LAT.
  - ack is in cycle MEM_LAT+1.
  - Next grant no earlier than cycle MEM_LAT+2.
  - Throughput is one access per MEM_LAT+2 cycles.
- Illegal access: ack with `err_o=1` in cycle 1; no strobe ever asserts.
- Simultaneous requests in IDLE: exactly one grant. The loser waits and is granted on the next IDLE cycle if still requesting.
- Reset asserted mid-ACCESS:
  - Strobes and acks drop immediately (asynchronous) and no ack is issued.
  - A write interrupted mid-window may be partially applied; requesters must reissue after reset.
- `stall0_o` is combinational and falls in the ack0 cycle.

## Structure
- Package `dmem_arb_pkg` contains:
  - the state enum (IDLE/ACCESS/RESP);
  - port id constants `PORT_CPU=0` and `PORT_DBG=1`;
  - the `lat_cnt` width constant (3 bits).
- Sub-module `rr_arb2`: a combinational two-way picker with inputs req[1:0], last_gnt and fixed_prio, producing a one-hot grant. Instantiated once.
- Address check, operand latches, counter and FSM live in `dmem_arbiter`.

## Test plan
- **Write then read, MEM_LAT=1:** port0 writes 0xDEADBEEF to 0x08, then reads 0x08.
  - memwrite_o is high in exactly 1 cycle.
  - ack0 arrives 2 cycles after each request.
  - rdata_o = 0xDEADBEEF.
- **Simultaneous requests from reset, both reading 0x00 repeatedly:** grants alternate 0,1,0,1. With FIXED_PRIO=1, port 1 is starved while req0 is held.
- **Misaligned access:** port1 reads 0x05. ack1 with err_o=1 in cycle 1, rdata_o=0, memread_o never asserts.
- **Out-of-range access:** port0 writes 0x1D with DEPTH=32. err_o=1 and no memwrite_o.
- **Longer window, MEM_LAT=3:** port0 reads. memread_o is high for 3 consecutive cycles, ack0 in cycle 4, stall0_o is high in cycles 0..3.
- **Reset during access:** rst_i is pulled low in the second ACCESS cycle with MEM_LAT=3.
  - All outputs go to 0 at once and no ack is issued.
  - After release, the next simultaneous request is granted to port 0.
